// File: rtl/lock_pkg.sv
// Shared types and command-bit layout for the canal lock sequencer.
package lock_pkg;

  localparam int unsigned CMD_W = 7;

  localparam int unsigned CMD_LOWER  = 0;
  localparam int unsigned CMD_RAISE  = 1;
  localparam int unsigned CMD_INNER  = 2;
  localparam int unsigned CMD_OUTER  = 3;
  localparam int unsigned CMD_ARRIVE = 4;
  localparam int unsigned CMD_DEPART = 5;
  localparam int unsigned CMD_RSVD   = 6;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    EQ_ENTRY,
    OPEN_ENTRY,
    CLOSE_ENTRY,
    EQ_EXIT,
    OPEN_EXIT,
    CLOSE_EXIT,
    FAULT
  } state_t;

  typedef enum logic {
    IN,
    OUT
  } dir_t;

  // Water-moving command; the compare guarantees raise and lower are exclusive.
  function automatic cmd_t water_cmd(input logic raise, input logic lower);
    cmd_t c;
    c = '0;
    c[CMD_RAISE] = raise;
    c[CMD_LOWER] = lower;
    return c;
  endfunction

  // Gate command for the entry (entry=1) or exit side of a passage in direction d.
  function automatic cmd_t gate_cmd(input dir_t d, input logic entry);
    cmd_t c;
    logic outer;
    c = '0;
    outer = ((d == IN) == entry);
    c[CMD_OUTER]  = outer;
    c[CMD_INNER]  = ~outer;
    c[CMD_ARRIVE] = entry;
    c[CMD_DEPART] = ~entry;
    return c;
  endfunction

endpackage

// File: rtl/lock_sequencer_level_compare.sv
// Compares the chamber level against a target with saturating +/- tolerance.
module level_compare #(
  parameter int unsigned LVL_W = 8,
  parameter int unsigned TOL   = 1
) (
  input  logic [LVL_W-1:0] lock,
  input  logic [LVL_W-1:0] target,
  output logic             need_raise,
  output logic             need_lower,
  output logic             equal
);

  localparam int unsigned EW = LVL_W + 1;

  logic [EW-1:0] lock_ext;
  logic [EW-1:0] target_ext;
  logic [EW-1:0] tol_ext;
  logic [EW-1:0] max_ext;
  logic [EW-1:0] lo;
  logic [EW-1:0] hi_raw;
  logic [EW-1:0] hi;

  // Extra bit keeps target+TOL from wrapping before saturation.
  always_comb begin
    lock_ext   = {1'b0, lock};
    target_ext = {1'b0, target};
    tol_ext    = EW'(TOL);
    max_ext    = {1'b0, {LVL_W{1'b1}}};
    lo         = (target_ext >= tol_ext) ? (target_ext - tol_ext) : '0;
    hi_raw     = target_ext + tol_ext;
    hi         = (hi_raw > max_ext) ? max_ext : hi_raw;
    need_raise = (lock_ext < lo);
    need_lower = (lock_ext > hi);
    equal      = ~need_raise & ~need_lower;
  end

endmodule

// File: rtl/lock_sequencer.sv
// Canal lock passage sequencer: turns gondola requests into registered lock commands.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned LEVEL_TOL = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             gondola_present,
  input  logic [LVL_W-1:0] inner_level,
  input  logic [LVL_W-1:0] lock_level,
  input  logic [LVL_W-1:0] outer_level,
  output logic [6:0]       cmd,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t           state;
  dir_t             dir;
  dir_t             last_dir;
  logic [TMR_W-1:0] timer;

  dir_t             req_dir_c;
  dir_t             sel_dir_c;
  logic             use_exit_c;
  logic [LVL_W-1:0] target_c;
  logic             need_raise_c;
  logic             need_lower_c;
  logic             equal_c;
  logic             waiting_c;
  logic             progress_c;

  // Round-robin arbitration and target selection for the single comparator.
  always_comb begin
    if (req_in && req_out) req_dir_c = (last_dir == OUT) ? IN : OUT;
    else if (req_in)       req_dir_c = IN;
    else                   req_dir_c = OUT;
    sel_dir_c  = (state == IDLE) ? req_dir_c : dir;
    use_exit_c = (state == CLOSE_ENTRY) || (state == EQ_EXIT) ||
                 (state == OPEN_EXIT)   || (state == CLOSE_EXIT);
    target_c   = ((sel_dir_c == IN) != use_exit_c) ? outer_level : inner_level;
  end

  level_compare #(
    .LVL_W (LVL_W),
    .TOL   (LEVEL_TOL)
  ) u_cmp (
    .lock       (lock_level),
    .target     (target_c),
    .need_raise (need_raise_c),
    .need_lower (need_lower_c),
    .equal      (equal_c)
  );

  // Waiting states and the condition that lets each one advance.
  always_comb begin
    waiting_c  = 1'b0;
    progress_c = 1'b0;
    case (state)
      EQ_ENTRY, EQ_EXIT: begin waiting_c = 1'b1; progress_c = equal_c;          end
      OPEN_ENTRY:        begin waiting_c = 1'b1; progress_c = gondola_present;  end
      OPEN_EXIT:         begin waiting_c = 1'b1; progress_c = ~gondola_present; end
      default:           begin waiting_c = 1'b0; progress_c = 1'b0;             end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dir      <= OUT;
      last_dir <= OUT;
      timer    <= '0;
      cmd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd  <= '0;
          busy <= 1'b0;
          if (req_in || req_out) begin
            dir   <= req_dir_c;
            state <= EQ_ENTRY;
            timer <= '0;
            busy  <= 1'b1;
            cmd   <= water_cmd(need_raise_c, need_lower_c);
          end
        end
        EQ_ENTRY: begin
          if (progress_c) begin
            state <= OPEN_ENTRY;
            timer <= '0;
            cmd   <= gate_cmd(dir, 1'b1);
          end else begin
            timer <= timer + TMR_W'(1);
            cmd   <= water_cmd(need_raise_c, need_lower_c);
          end
        end
        OPEN_ENTRY: begin
          if (progress_c) begin
            state <= CLOSE_ENTRY;
            timer <= '0;
            cmd   <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
            cmd   <= gate_cmd(dir, 1'b1);
          end
        end
        CLOSE_ENTRY: begin
          state <= EQ_EXIT;
          timer <= '0;
          cmd   <= water_cmd(need_raise_c, need_lower_c);
        end
        EQ_EXIT: begin
          if (progress_c) begin
            state <= OPEN_EXIT;
            timer <= '0;
            cmd   <= gate_cmd(dir, 1'b0);
          end else begin
            timer <= timer + TMR_W'(1);
            cmd   <= water_cmd(need_raise_c, need_lower_c);
          end
        end
        OPEN_EXIT: begin
          if (progress_c) begin
            state <= CLOSE_EXIT;
            timer <= '0;
            cmd   <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
            cmd   <= gate_cmd(dir, 1'b0);
          end
        end
        CLOSE_EXIT: begin
          state    <= IDLE;
          timer    <= '0;
          cmd      <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          last_dir <= dir;
        end
        default: begin
          state <= FAULT;
          cmd   <= '0;
          busy  <= 1'b0;
          fault <= 1'b1;
        end
      endcase
      // A waiting state that has used its whole budget overrides the case above.
      if (waiting_c && !progress_c && (timer == TMR_W'(TIMEOUT - 1))) begin
        state <= FAULT;
        timer <= '0;
        cmd   <= '0;
        busy  <= 1'b0;
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with a +/-1 per cycle chamber model.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_in;
  logic       req_out;
  logic       gondola_present;
  logic [7:0] inner_level;
  logic [7:0] lock_level;
  logic [7:0] outer_level;
  logic [6:0] cmd;
  logic       busy;
  logic       done;
  logic       fault;

  int  checks   = 0;
  int  failures = 0;
  bit  freeze   = 1'b0;

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_LOWER  = 7'b0000001;
  localparam logic [6:0] C_RAISE  = 7'b0000010;
  localparam logic [6:0] C_OUT_AR = 7'b0011000;
  localparam logic [6:0] C_IN_AR  = 7'b0010100;
  localparam logic [6:0] C_IN_DP  = 7'b0100100;
  localparam logic [6:0] C_OUT_DP = 7'b0101000;

  lock_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .req_in          (req_in),
    .req_out         (req_out),
    .gondola_present (gondola_present),
    .inner_level     (inner_level),
    .lock_level      (lock_level),
    .outer_level     (outer_level),
    .cmd             (cmd),
    .busy            (busy),
    .done            (done),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  // Chamber model: one level step per cycle of raise/lower.
  always @(negedge clk) begin
    if (!freeze && rst) begin
      if (cmd[1]) lock_level = lock_level + 8'd1;
      if (cmd[0]) lock_level = lock_level - 8'd1;
    end
  end

  // Safety invariants on every cycle.
  always @(negedge clk) begin
    checks++;
    if ((cmd[0] && cmd[1]) || (cmd[2] && cmd[3]) ||
        ((cmd[2] || cmd[3]) && (cmd[0] || cmd[1])) || cmd[6]) begin
      failures++;
      $display("FAIL invariant t=%0t cmd=%b", $time, cmd);
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    req_in = 1'b0;
    req_out = 1'b0;
    gondola_present = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cmd(input logic [6:0] want, input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (cmd === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    freeze = 1'b1;
    inner_level = 8'd0; outer_level = 8'd0; lock_level = 8'd0;
    do_reset();
    @(negedge clk);
    checks++;
    if ({cmd, busy, done, fault} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state cmd=%b busy=%b done=%b fault=%b required all 0", cmd, busy, done, fault);
    end
  endtask

  task automatic test_inbound();
    bit ok;
    freeze = 1'b0;
    inner_level = 8'd20; outer_level = 8'd10; lock_level = 8'd3;
    do_reset();
    req_in = 1'b1;
    wait_cmd(C_OUT_AR, 40, ok);
    checks++;
    if (!ok || lock_level < 8'd9 || lock_level > 8'd11) begin
      failures++;
      $display("FAIL in_entry_open ok=%0d lock=%0d cmd=%b required cmd=%b lock 9..11", ok, lock_level, cmd, C_OUT_AR);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL in_busy busy=%b required 1", busy);
    end
    req_in = 1'b0;
    gondola_present = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd !== C_IDLE) begin
      failures++;
      $display("FAIL in_close_entry cmd=%b required %b", cmd, C_IDLE);
    end
    @(negedge clk);
    checks++;
    if (cmd !== C_RAISE) begin
      failures++;
      $display("FAIL in_one_cycle_closed cmd=%b required %b", cmd, C_RAISE);
    end
    wait_cmd(C_IN_DP, 40, ok);
    checks++;
    if (!ok || lock_level < 8'd19 || lock_level > 8'd21) begin
      failures++;
      $display("FAIL in_exit_open ok=%0d lock=%0d cmd=%b required cmd=%b lock 19..21", ok, lock_level, cmd, C_IN_DP);
    end
    gondola_present = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd !== C_IDLE || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL in_close_exit cmd=%b done=%b busy=%b required 0000000/0/1", cmd, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd !== C_IDLE) begin
      failures++;
      $display("FAIL in_done_pulse done=%b busy=%b cmd=%b required 1/0/0000000", done, busy, cmd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL in_done_single done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_outbound();
    bit ok;
    freeze = 1'b0;
    inner_level = 8'd20; outer_level = 8'd10; lock_level = 8'd20;
    do_reset();
    req_out = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd !== C_IDLE || busy !== 1'b1) begin
      failures++;
      $display("FAIL out_no_entry_move cmd=%b busy=%b required 0000000/1", cmd, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd !== C_IN_AR) begin
      failures++;
      $display("FAIL out_entry_open cmd=%b required %b", cmd, C_IN_AR);
    end
    req_out = 1'b0;
    gondola_present = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd !== C_LOWER) begin
      failures++;
      $display("FAIL out_lowering cmd=%b required %b", cmd, C_LOWER);
    end
    wait_cmd(C_OUT_DP, 40, ok);
    checks++;
    if (!ok || lock_level < 8'd9 || lock_level > 8'd11) begin
      failures++;
      $display("FAIL out_exit_open ok=%0d lock=%0d cmd=%b required cmd=%b lock 9..11", ok, lock_level, cmd, C_OUT_DP);
    end
    gondola_present = 1'b0;
    wait_done(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL out_done done=%b required pulse within 10 cycles", done);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    freeze = 1'b0;
    inner_level = 8'd10; outer_level = 8'd10; lock_level = 8'd10;
    do_reset();
    req_in = 1'b1;
    req_out = 1'b1;
    wait_cmd(C_OUT_AR, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_first_in cmd=%b required %b", cmd, C_OUT_AR);
    end
    gondola_present = 1'b1;
    wait_cmd(C_IN_DP, 10, ok);
    gondola_present = 1'b0;
    wait_done(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_first_done done=%b required pulse", done);
    end
    wait_cmd(C_IN_AR, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_second_out cmd=%b required %b", cmd, C_IN_AR);
    end
    req_in = 1'b0;
    req_out = 1'b0;
    gondola_present = 1'b1;
    wait_cmd(C_OUT_DP, 10, ok);
    gondola_present = 1'b0;
    wait_done(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_second_done done=%b required pulse", done);
    end
  endtask

  task automatic test_timeout();
    int n;
    freeze = 1'b1;
    inner_level = 8'd20; outer_level = 8'd20; lock_level = 8'd3;
    do_reset();
    req_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (fault === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n < 64 || n > 66) begin
      failures++;
      $display("FAIL timeout_cycles fault_after=%0d required 64..66", n);
    end
    req_in = 1'b0;
    repeat (4) begin
      @(negedge clk);
      req_out = ~req_out;
      req_in = ~req_in;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || cmd !== C_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky fault=%b cmd=%b busy=%b required 1/0000000/0", fault, cmd, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear fault=%b required 0", fault);
    end
    req_in = 1'b0;
    req_out = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    freeze = 1'b0;
    inner_level = 8'd10; outer_level = 8'd10; lock_level = 8'd10;
    do_reset();
    req_in = 1'b1;
    gondola_present = 1'b0;
    wait_cmd(C_OUT_AR, 10, ok);
    req_in = 1'b0;
    gondola_present = 1'b1;
    wait_cmd(C_IN_DP, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_reach_open_exit cmd=%b required %b", cmd, C_IN_DP);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cmd !== C_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_reset cmd=%b busy=%b required 0000000/0", cmd, busy);
    end
    gondola_present = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd !== C_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle cmd=%b busy=%b required 0000000/0", cmd, busy);
    end
    freeze = 1'b1;
    lock_level = 8'd5;
    req_in = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd !== C_RAISE || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart cmd=%b busy=%b required %b/1", cmd, busy, C_RAISE);
    end
    req_in = 1'b0;
  endtask

  task automatic test_edge_levels();
    logic [7:0] tgt [5];
    logic [7:0] lck [5];
    logic [6:0] exp [5];
    tgt[0] = 8'd255; lck[0] = 8'd254; exp[0] = C_IDLE;
    tgt[1] = 8'd0;   lck[1] = 8'd1;   exp[1] = C_IDLE;
    tgt[2] = 8'd255; lck[2] = 8'd253; exp[2] = C_RAISE;
    tgt[3] = 8'd0;   lck[3] = 8'd2;   exp[3] = C_LOWER;
    tgt[4] = 8'd0;   lck[4] = 8'd0;   exp[4] = C_IDLE;
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inner_level = 8'd128;
      outer_level = tgt[i];
      lock_level  = lck[i];
      do_reset();
      req_in = 1'b1;
      @(negedge clk);
      req_in = 1'b0;
      checks++;
      if (cmd !== exp[i]) begin
        failures++;
        $display("FAIL edge_level[%0d] target=%0d lock=%0d cmd=%b required %b", i, tgt[i], lck[i], cmd, exp[i]);
      end
      @(negedge clk);
      checks++;
      if ((exp[i] == C_IDLE) && (cmd !== C_OUT_AR)) begin
        failures++;
        $display("FAIL edge_open[%0d] cmd=%b required %b", i, cmd, C_OUT_AR);
      end else if ((exp[i] != C_IDLE) && (cmd !== exp[i])) begin
        failures++;
        $display("FAIL edge_hold[%0d] cmd=%b required %b", i, cmd, exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_in = 1'b0;
    req_out = 1'b0;
    gondola_present = 1'b0;
    inner_level = 8'd0;
    outer_level = 8'd0;
    lock_level = 8'd0;
    test_reset();
    test_inbound();
    test_outbound();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_edge_levels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
